// File: rtl/dmem_bridge.sv
// dmem_bridge: stalls the core's single-cycle data port over a req/ack bus.
// Optional bus timeout is compiled in with DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge #(
  parameter int ADDR_W         = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  input  logic              core_we,
  input  logic              core_oe,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic accept;
  logic busy;
  logic expire;

  assign busy       = (state_q == BUSY);
  assign accept     = (state_q == IDLE) && (core_we || core_oe);
  assign core_stall = accept || busy;
  assign mem_req    = busy;

  logic unused_bits;
  assign unused_bits = ^core_addr[1:0];

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic        err_q;

  assign expire  = busy && !mem_ack && (cnt_q == TO_LAST);
  assign bus_err = err_q;

  // busy-cycle counter, restarted for every accepted access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (busy && !mem_ack) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // error flag is high only in the DONE cycle that follows an abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= expire;
    end
  end
`else
  logic [15:0] unused_to;
  assign unused_to = 16'(TIMEOUT_CYCLES);
  assign expire    = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state; DONE never accepts, the held request is the retiring one
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (mem_ack || expire) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // request latches, stable for the whole BUSY phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (accept) begin
      mem_addr  <= core_addr[ADDR_W+1:2];
      mem_wdata <= core_wdata;
      mem_we    <= core_we;
    end
  end

  // load data return; writes leave it untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rdata <= '0;
    end else if (busy && !mem_we) begin
      if (mem_ack) begin
        core_rdata <= mem_rdata;
      end else if (expire) begin
        core_rdata <= 32'hDEAD_BEEF;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed and random accesses against a transaction model.
// Timeout cases run only when DMEM_BRIDGE_TIMEOUT_EN is defined.
module tb_dmem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_we = 1'b0;
  logic        core_oe = 1'b0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rd = '0;

  dmem_bridge #(
    .ADDR_W(30),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_we(core_we),
    .core_oe(core_oe),
    .core_rdata(core_rdata),
    .core_stall(core_stall),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // One core access; k<0 means the bus never acks. Called at negedge+1.
  task automatic access(input bit we, input bit oe,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int k, input logic [31:0] rd,
                        output int low_before);
    bit exp_to;
    int exp_req;
    int stall_cnt;
    int req_cnt;
    bit done;
    logic [31:0] exp_rd;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    exp_to = (k < 0) || (k + 1 > TO);
`else
    exp_to = 1'b0;
`endif
    exp_req = exp_to ? TO : k + 1;
    exp_rd = we ? model_rd : (exp_to ? 32'hDEAD_BEEF : rd);
    stall_cnt = 0;
    req_cnt = 0;
    done = 0;
    low_before = 0;
    core_we = we;
    core_oe = oe;
    core_addr = addr;
    core_wdata = wd;
    #1;
    for (int c = 0; c < 100 && !done; c++) begin
      if (core_stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        check("mem_addr", 32'(mem_addr), addr >> 2);
        check("mem_we", 32'(mem_we), 32'(we));
        check("mem_wdata", mem_wdata, wd);
        if (k >= 0 && req_cnt == k + 1) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
      end else if (req_cnt == 0) begin
        low_before++;
      end else begin
        done = 1;
        model_rd = exp_rd;
        check("req_cycles", req_cnt, exp_req);
        check("stall_cycles", stall_cnt, exp_req + 1);
        check("core_rdata", core_rdata, model_rd);
        check("bus_err", 32'(bus_err), 32'(exp_to));
        core_we = 1'b0;
        core_oe = 1'b0;
      end
      if (!done) begin
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        #1;
      end
    end
    check("done_seen", 32'(done), 32'd1);
    core_we = 1'b0;
    core_oe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    bit rw;
    bit ro;
    #12;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(core_stall), 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_req", 32'(mem_req), 32'd0);
    check("stray_stall", 32'(core_stall), 32'd0);
    check("stray_rdata", core_rdata, 32'd0);
    idle(1);

    access(0, 1, 32'h10, 32'h0, 0, 32'hCAFE_0001, low);
    idle(1);
    access(1, 0, 32'h23, 32'h1234_5678, 5, 32'h0BAD_0BAD, low);
    idle(1);
    access(1, 1, 32'h40, 32'hA5A5_5A5A, 1, 32'h0BAD_F00D, low);
    idle(2);
    access(0, 1, 32'h0, 32'h0, 0, 32'h0000_AAAA, low);
    access(0, 1, 32'h4, 32'h0, 0, 32'h0000_BBBB, low);
    check("b2b_gap", low, 2);
    check("after_b2b_req", 32'(mem_req), 32'd0);
    idle(1);
    check("after_b2b_stall", 32'(core_stall), 32'd0);
    check("after_b2b_rdata", core_rdata, 32'h0000_BBBB);

    core_oe = 1'b1;
    core_addr = 32'h80;
    @(negedge clk);
    #1;
    check("rmid_busy", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rmid_req", 32'(mem_req), 32'd0);
    check("rmid_rdata", core_rdata, 32'd0);
    check("rmid_addr", 32'(mem_addr), 32'd0);
    core_oe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_5555;
    model_rd = '0;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("rmid_ack_req", 32'(mem_req), 32'd0);
    check("rmid_ack_stall", 32'(core_stall), 32'd0);
    check("rmid_ack_rdata", core_rdata, 32'd0);
    idle(1);
    check("rmid_ack_rdata2", core_rdata, 32'd0);

    for (int i = 0; i < 24; i++) begin
      rw = 1'($urandom);
      ro = rw ? 1'($urandom) : 1'b1;
      access(rw, ro, $urandom, $urandom, int'($urandom_range(0, 6)),
             $urandom, low);
      idle(int'($urandom_range(0, 2)));
    end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    idle(1);
    access(0, 1, 32'h100, 32'h0, -1, 32'h0, low);
    idle(1);
    access(0, 1, 32'h104, 32'h0, 3, 32'h7777_1234, low);
    idle(1);
    access(1, 0, 32'h108, 32'h9999_0000, -1, 32'h0, low);
    idle(1);
    check("to_after_rdata", core_rdata, 32'h7777_1234);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
